mano_loader: RTL and testbench

MANO_LOADER -- requirements
Module: mano_loader

---
 rtl/mano_loader_pkg.sv | 11 +
 rtl/mano_loader_cksum.sv | 15 +
 rtl/mano_loader.sv | 86 ++++++++
 tb/tb_mano_loader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mano_loader_pkg.sv
// mano_loader_pkg: shared state encoding, widths and frame-length helper for the Mano image loader
package mano_loader_pkg;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;
   // A LEN byte of zero stands for a full 256-byte image.
   localparam logic [8:0] LEN_ZERO = 9'd256;
   typedef enum logic [2:0] {IDLE, GET_LEN, DATA, CHECK, RUN, ERR} state_t;
   function automatic logic [8:0] frame_len(input logic [DATA_W-1:0] b);
      return (b == '0) ? LEN_ZERO : {1'b0, b};
   endfunction
endpackage

// File: rtl/mano_loader_cksum.sv
// mano_loader_cksum: 8-bit wrapping running sum; ports clk, rst, clr (zero the sum), en (add din), din, sum
module mano_loader_cksum
   import mano_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] sum
);
   always_ff @(posedge clk)
      if (rst || clr) sum <= '0;
      else if (en) sum <= sum + din;
endmodule

// File: rtl/mano_loader.sv
// mano_loader: streams a BASE/LEN/data/CSUM frame into Mano memory, then releases the CPU at BASE
// ports: clk, rst; in_data/in_valid/in_ready byte stream; reload; mem_we/mem_addr/mem_wdata write port;
//        cpu_hold, cpu_start, pc_init CPU control; load_err, busy status
module mano_loader
   import mano_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              reload,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_hold,
   output logic              cpu_start,
   output logic [ADDR_W-1:0] pc_init,
   output logic              load_err,
   output logic              busy
);
   state_t            state;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] ptr;
   logic [8:0]        cnt;
   logic [DATA_W-1:0] sum;
   logic              hs;
   assign in_ready = (state != RUN) && (state != ERR);
   assign hs       = in_valid && in_ready;
   assign cpu_hold = (state != RUN);
   assign load_err = (state == ERR);
   assign busy     = (state == GET_LEN) || (state == DATA) || (state == CHECK);
   // The sum is cleared while the LEN byte is awaited so each frame starts from zero.
   mano_loader_cksum u_cksum (
      .clk (clk),
      .rst (rst),
      .clr (state == GET_LEN),
      .en  (hs && (state == DATA)),
      .din (in_data),
      .sum (sum)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         base      <= '0;
         ptr       <= '0;
         cnt       <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_start <= 1'b0;
         pc_init   <= '0;
      end else begin
         mem_we    <= 1'b0;
         cpu_start <= 1'b0;
         case (state)
            IDLE: if (hs) begin
               base  <= in_data;
               state <= GET_LEN;
            end
            GET_LEN: if (hs) begin
               cnt   <= frame_len(in_data);
               ptr   <= base;
               state <= DATA;
            end
            DATA: if (hs) begin
               mem_we    <= 1'b1;
               mem_addr  <= ptr;
               mem_wdata <= in_data;
               ptr       <= ptr + 1'b1;
               cnt       <= cnt - 1'b1;
               if (cnt == 9'd1) state <= CHECK;
            end
            CHECK: if (hs) begin
               if (in_data == sum) begin
                  state     <= RUN;
                  cpu_start <= 1'b1;
                  pc_init   <= base;
               end else state <= ERR;
            end
            RUN, ERR: if (reload) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mano_loader.sv
// tb_mano_loader: directed and randomized frames checked against a byte-level reference of the frame rules
module tb_mano_loader;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       reload = 1'b0;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       cpu_hold;
   logic       cpu_start;
   logic [7:0] pc_init;
   logic       load_err;
   logic       busy;

   int total = 0;
   int fails = 0;
   logic [15:0] wr_q[$];
   int          start_cnt = 0;
   logic        start_hold = 1'b1;
   logic [7:0]  start_pc = 8'h00;
   logic [7:0]  dbuf[256];

   mano_loader dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .cpu_start(cpu_start), .pc_init(pc_init), .load_err(load_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we === 1'b1) wr_q.push_back({mem_addr, mem_wdata});
      if (cpu_start === 1'b1) begin
         start_cnt++;
         start_hold = cpu_hold;
         start_pc = pc_init;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gaps);
      int n = 0;
      repeat (gaps) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data = b;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("ready_timeout", 32'(n < 50), 32'd1);
   endtask

   function automatic int pick_gap(input int mode);
      return (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
   endfunction

   // Sends one frame from dbuf and compares the written bytes and the final outcome
   // against the frame rules: byte k lands at (base+k) mod 256, RUN iff csum == sum mod 256.
   task automatic run_frame(input logic [7:0] base, input logic [7:0] len, input logic [7:0] csum,
                            input int mode, input string tag);
      int nb = (len == 8'h00) ? 256 : int'(len);
      int s = 0;
      int s0 = start_cnt;
      bit good;
      wr_q.delete();
      for (int k = 0; k < nb; k++) s = (s + int'(dbuf[k])) % 256;
      good = (int'(csum) == s);
      send_byte(base, pick_gap(mode));
      send_byte(len, pick_gap(mode));
      for (int k = 0; k < nb; k++) send_byte(dbuf[k], pick_gap(mode));
      send_byte(csum, pick_gap(mode));
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check({tag, "_nwrites"}, 32'(wr_q.size()), 32'(nb));
      for (int k = 0; k < nb && k < wr_q.size(); k++)
         check({tag, "_write"}, 32'(wr_q[k]), 32'({8'((int'(base) + k) % 256), dbuf[k]}));
      check({tag, "_starts"}, 32'(start_cnt - s0), good ? 32'd1 : 32'd0);
      if (good) begin
         check({tag, "_start_hold"}, 32'(start_hold), 32'd0);
         check({tag, "_pc_init"}, 32'(start_pc), 32'(base));
      end
      check({tag, "_load_err"}, 32'(load_err), good ? 32'd0 : 32'd1);
      check({tag, "_cpu_hold"}, 32'(cpu_hold), good ? 32'd0 : 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
   endtask

   task automatic do_reload(input string tag);
      @(negedge clk);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      check({tag, "_rl_load_err"}, 32'(load_err), 32'd0);
      check({tag, "_rl_cpu_hold"}, 32'(cpu_hold), 32'd1);
      check({tag, "_rl_in_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_rl_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      check("rst_cpu_start", 32'(cpu_start), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check("rst_pc_init", 32'(pc_init), 32'd0);
      check("rst_load_err", 32'(load_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'd1);

      dbuf[0] = 8'h01; dbuf[1] = 8'h02; dbuf[2] = 8'h55;
      run_frame(8'h00, 8'h03, 8'h58, 0, "basic");

      // RUN must refuse bytes and keep the CPU running.
      wr_q.delete();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data = 8'hFF;
         check("run_in_ready", 32'(in_ready), 32'd0);
         check("run_cpu_hold", 32'(cpu_hold), 32'd0);
      end
      check("run_nwrites", 32'(wr_q.size()), 32'd0);
      // Reload with a byte on offer: the byte must not be taken, so the loader stays idle.
      @(negedge clk);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      in_valid = 1'b0;
      check("rl_valid_busy", 32'(busy), 32'd0);
      check("rl_valid_hold", 32'(cpu_hold), 32'd1);
      check("rl_valid_ready", 32'(in_ready), 32'd1);

      dbuf[0] = 8'hAA; dbuf[1] = 8'hBB; dbuf[2] = 8'hCC;
      run_frame(8'hFE, 8'h03, 8'h31, 0, "wrap");
      do_reload("wrap");

      dbuf[0] = 8'h05; dbuf[1] = 8'h06;
      run_frame(8'h10, 8'h02, 8'h00, 0, "bad");
      repeat (3) @(negedge clk);
      check("err_sticky", 32'(load_err), 32'd1);
      check("err_hold", 32'(cpu_hold), 32'd1);
      do_reload("bad");

      dbuf[0] = 8'hDC;
      run_frame(8'h00, 8'h01, 8'hDC, 1, "gaps");
      do_reload("gaps");

      // Reset after the second data byte of a four-byte frame.
      wr_q.delete();
      send_byte(8'h20, 0);
      send_byte(8'h04, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      @(negedge clk);
      rst = 1'b1;
      in_data = 8'h33;
      @(negedge clk);
      check("mid_rst_mem_we", 32'(mem_we), 32'd0);
      check("mid_rst_hold", 32'(cpu_hold), 32'd1);
      check("mid_rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_rst_nwrites", 32'(wr_q.size()), 32'd2);
      if (wr_q.size() == 2) begin
         check("mid_rst_w0", 32'(wr_q[0]), 32'h2011);
         check("mid_rst_w1", 32'(wr_q[1]), 32'h2122);
      end
      dbuf[0] = 8'h07; dbuf[1] = 8'h08; dbuf[2] = 8'h09; dbuf[3] = 8'h0A;
      run_frame(8'h40, 8'h04, 8'h22, 0, "fresh");
      do_reload("fresh");

      for (int i = 0; i < 6; i++) begin
         logic [7:0] len = (i == 2) ? 8'h00 : 8'($urandom_range(1, 12));
         logic [7:0] base = 8'($urandom);
         int nb = (len == 8'h00) ? 256 : int'(len);
         int s = 0;
         logic [7:0] cs;
         for (int k = 0; k < nb; k++) begin
            dbuf[k] = 8'($urandom);
            s = (s + int'(dbuf[k])) % 256;
         end
         cs = ($urandom_range(0, 3) == 0) ? 8'(s + int'($urandom_range(1, 255))) : 8'(s);
         run_frame(base, len, cs, 2, "rand");
         do_reload("rand");
      end

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule
